pipemdu: RTL and testbench

Multi-cycle multiply/divide sequencer that sits beside the EXE-stage ALU of the five-stage pipeline and owns the HI/LO registers. The ALU is single-cycle; MULT/MULTU/DIV/DIVU need 32 iterations. This block accepts an op from EXE, iterates, and writes HI/LO. While it is busy it asserts a stall to the pipeline control for any instruction that touches it.

---
 rtl/pipemdu_pkg.sv | 33 +++
 rtl/mdu_step.sv | 31 +++
 rtl/pipemdu.sv | 114 +++++++++++
 tb/tb_pipemdu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipemdu_pkg.sv
// Shared encodings and types for the pipelined multiply/divide unit.
// Op and state encodings, the iteration count, and the latched per-op control word.
package pipemdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } mdu_state_e;

  // Sign fix-up decisions are taken at issue time so FIX only applies them.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (dividend sign)
    logic dz;      // divide by zero
  } mdu_ctl_t;

  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// acc holds {hi, lo}; lo carries the multiplier (mul) or dividend/quotient bits (div).
module mdu_step
  import pipemdu_pkg::*;
#(
  parameter int XLEN = MDU_ITER
) (
  input  logic              mode,     // 0: multiply, 1: divide
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,     // multiplicand or divisor magnitude
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]   msum;
  logic [XLEN:0]   dtop;
  logic [XLEN-1:0] dsub;
  logic            dge;

  always_comb begin
    msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // partial remainder shifted left with the next dividend bit brought in
    dtop    = acc[2*XLEN-1:XLEN-1];
    dge     = dtop >= {1'b0, opnd};
    dsub    = dtop[XLEN-1:0] - opnd;
    acc_nxt = {msum, acc[XLEN-1:1]};
    if (mode)
      acc_nxt = dge ? {dsub, acc[XLEN-2:0], 1'b1}
                    : {dtop[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/pipemdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO beside the EXE-stage ALU.
// 32 iterations on magnitudes plus one FIX cycle for signs; stalls EXE users while busy.
module pipemdu
  import pipemdu_pkg::*;
#(
  parameter int XLEN  = MDU_ITER,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            estart,
  input  logic [1:0]      eop,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic            ewhi,
  input  logic            ewlo,
  input  logic            erhilo,
  output logic [XLEN-1:0] ehi,
  output logic [XLEN-1:0] elo,
  output logic            ebusy,
  output logic            edone,
  output logic            estall
);

  mdu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  mdu_ctl_t          ctl;

  logic [2*XLEN-1:0] acc_nxt;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   amag, bmag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign estall = ebusy & (estart | ewhi | ewlo | erhilo);

  always_comb begin
    a_neg = op_signed(eop) & ea[XLEN-1];
    b_neg = op_signed(eop) & eb[XLEN-1];
    amag  = a_neg ? -ea : ea;
    bmag  = b_neg ? -eb : eb;
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .mode    (state == S_DIV),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  // On divide by zero the remainder magnitude equals |ea| and regains ea's sign,
  // so HI = ea falls out naturally; only LO needs forcing.
  always_comb begin
    prod = ctl.neg_q ? -acc : acc;
    quo  = ctl.neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = ctl.neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (ctl.is_div) begin
      fix_hi = rem;
      fix_lo = ctl.dz ? '1 : quo;
    end else begin
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      ctl   <= '0;
      ehi   <= '0;
      elo   <= '0;
      ebusy <= 1'b0;
      edone <= 1'b0;
    end else begin
      edone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (estart) begin
            ctl   <= '{is_div: eop[1], neg_q: a_neg ^ b_neg, neg_r: a_neg,
                       dz: eop[1] & (eb == '0)};
            acc   <= {{XLEN{1'b0}}, (eop[1] ? amag : bmag)};
            opnd  <= eop[1] ? bmag : amag;
            cnt   <= '0;
            ebusy <= 1'b1;
            state <= eop[1] ? S_DIV : S_MUL;
          end else begin
            if (ewhi) ehi <= ea;
            if (ewlo) elo <= ea;
          end
        end
        S_MUL, S_DIV: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= S_FIX;
        end
        S_FIX: begin
          ehi   <= fix_hi;
          elo   <= fix_lo;
          edone <= 1'b1;
          ebusy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipemdu.sv
// Self-checking bench for pipemdu: cycle-level behavioural model checked every cycle,
// directed vectors with literal results, then randomized traffic.
module tb_pipemdu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        estart = 1'b0;
  logic [1:0]  eop = 2'b00;
  logic [31:0] ea = '0, eb = '0;
  logic        ewhi = 1'b0, ewlo = 1'b0, erhilo = 1'b0;
  logic [31:0] ehi, elo;
  logic        ebusy, edone, estall;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] mhi, mlo, phi, plo;
  int          mleft = 0;
  bit          mdone = 0;
  bit          mstarted = 0;

  always #5 clock = ~clock;

  pipemdu dut (
    .clock  (clock),
    .reset  (reset),
    .estart (estart),
    .eop    (eop),
    .ea     (ea),
    .eb     (eb),
    .ewhi   (ewhi),
    .ewlo   (ewlo),
    .erhilo (erhilo),
    .ehi    (ehi),
    .elo    (elo),
    .ebusy  (ebusy),
    .edone  (edone),
    .estall (estall)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    h = '0; l = '0;
    case (op)
      2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); {h, l} = p; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; {h, l} = u; end
      2'b10: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
        else begin sa = a; sb = b; l = sa / sb; h = sa % sb; end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // One result lands 33 edges after the issuing edge; writes and new ops are ignored meanwhile.
  task automatic model_step();
    if (reset) begin
      mhi = 0; mlo = 0; mleft = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (mleft > 0) begin
        mleft--;
        if (mleft == 0) begin mhi = phi; mlo = plo; mdone = 1; end
      end else if (estart) begin
        ref_calc(eop, ea, eb, phi, plo);
        mleft = 33;
      end else begin
        if (ewhi) mhi = ea;
        if (ewlo) mlo = ea;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (mstarted) begin
      chk("ehi", ehi, mhi);
      chk("elo", elo, mlo);
      chk("ebusy", ebusy, mleft > 0);
      chk("edone", edone, mdone);
      chk("estall", estall, (mleft > 0) && (estart | ewhi | ewlo | erhilo));
    end
    @(posedge clock);
    model_step();
    mstarted = 1;
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] xhi, input logic [31:0] xlo, input string nm);
    int bc;
    bit seen;
    estart = 1; eop = op; ea = a; eb = b;
    tick();
    estart = 0; ea = 0; eb = 0;
    bc = 0; seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (edone) seen = 1;
      else begin
        if (ebusy) bc++;
        tick();
      end
    end
    chk({nm, "_done"}, seen, 1);
    chk({nm, "_busy"}, bc, 33);
    chk({nm, "_hi"}, ehi, xhi);
    chk({nm, "_lo"}, elo, xlo);
  endtask

  function automatic logic [31:0] rv();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 0;
      1: v = 1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = $urandom_range(0, 20);
      5: v = 32'(-int'($urandom_range(1, 20)));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int nd;
    bit seen;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_hi", ehi, 0);
    chk("rst_lo", elo, 0);
    chk("rst_busy", ebusy, 0);

    issue(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu");
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    issue(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, "divu0");
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "divovf");
    issue(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "divneg0");

    // requests while busy stall and are ignored
    estart = 1; eop = 2'b00; ea = 32'h12345; eb = 32'h1000;
    tick();
    estart = 0; erhilo = 1;
    #1 chk("stall_rd", estall, 1);
    tick();
    erhilo = 0; estart = 1; ea = 9; eb = 9;
    #1 chk("stall_start", estall, 1);
    tick();
    estart = 0; ewlo = 1; ea = 5;
    #1 chk("stall_mtlo", estall, 1);
    tick();
    ewlo = 0; ea = 0; eb = 0;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (edone) seen = 1; else tick();
    end
    chk("stall_done", seen, 1);
    chk("stall_hi", ehi, 0);
    chk("stall_lo", elo, 32'h12345000);
    ewlo = 1; ea = 5;
    tick();
    ewlo = 0; ea = 0;
    chk("mtlo_after", elo, 5);

    // reset mid divide
    estart = 1; eop = 2'b10; ea = 1000; eb = 7;
    tick();
    estart = 0; ea = 0; eb = 0;
    repeat (9) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_busy", ebusy, 0);
    chk("midrst_hi", ehi, 0);
    chk("midrst_lo", elo, 0);
    chk("midrst_done", edone, 0);
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      if (edone) nd++;
      tick();
    end
    chk("midrst_nodone", nd, 0);
    issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, "mult67");

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 2500; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      estart = ($urandom_range(0, 7) == 0);
      eop    = 2'($urandom_range(0, 3));
      ea     = rv();
      eb     = rv();
      ewhi   = ($urandom_range(0, 5) == 0);
      ewlo   = ($urandom_range(0, 5) == 0);
      erhilo = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 0; estart = 0; ewhi = 0; ewlo = 0; erhilo = 0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
